// File: rtl/pll_reset_ctrl.sv
// PLL power-up / recovery sequencer: power-down, reset, lock wait, stability qualification, retry and fault.
// Optional lock-loss glitch filter in RUN: define PLL_RESET_CTRL_GLITCH_FILTER_EN.
module pll_reset_ctrl #(
    parameter int unsigned PWD_CYCLES    = 4,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
`ifdef PLL_RESET_CTRL_GLITCH_FILTER_EN
    ,
    parameter int unsigned GLITCH_CYCLES = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       soft_restart,
    output logic       pll_pwd,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        ST_PWD       = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [15:0] PWD_LAST     = 16'(PWD_CYCLES - 1);
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    logic [1:0]  sync_r;
    logic        lock_s;
    logic        loss_s;
    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [3:0]  retry_r;
    logic [3:0]  retry_s;
    logic [7:0]  lost_r;
    logic [7:0]  lost_s;
    logic        pwd_s;
    logic        prst_s;
    logic        ready_s;
    logic        fault_s;

    assign lock_s        = sync_r[1];
    assign retry_cnt     = retry_r;
    assign lock_lost_cnt = lost_r;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_lock};
        end
    end

`ifdef PLL_RESET_CTRL_GLITCH_FILTER_EN
    localparam logic [7:0] GLITCH_LAST = 8'(GLITCH_CYCLES - 1);
    logic [7:0] glitch_r;

    // Consecutive low-sample counter, only armed while running
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_r <= 8'd0;
        end else if (soft_restart || (state_r != ST_RUN) || lock_s) begin
            glitch_r <= 8'd0;
        end else if (glitch_r != GLITCH_LAST) begin
            glitch_r <= glitch_r + 8'd1;
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign loss_s = !lock_s && (glitch_r == GLITCH_LAST);
`else
    assign loss_s = !lock_s;
`endif

    // Next-state, retry and lock-loss bookkeeping
    always_comb begin
        state_s = state_r;
        retry_s = retry_r;
        lost_s  = lost_r;
        if (soft_restart) begin
            state_s = ST_PWD;
            retry_s = 4'd0;
        end else begin
            case (state_r)
                ST_PWD: begin
                    if (cnt_r == PWD_LAST) state_s = ST_RST;
                    else                   state_s = ST_PWD;
                end
                ST_RST: begin
                    if (cnt_r == RST_LAST) state_s = ST_WAIT_LOCK;
                    else                   state_s = ST_RST;
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a simultaneous timeout
                    if (lock_s) begin
                        state_s = ST_STABLE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        if (retry_r == RETRY_LIMIT) begin
                            state_s = ST_FAULT;
                        end else begin
                            retry_s = retry_r + 4'd1;
                            state_s = ST_RST;
                        end
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_s = ST_WAIT_LOCK;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s = ST_RUN;
                        retry_s = 4'd0;
                    end else begin
                        state_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (loss_s) begin
                        state_s = ST_RST;
                        if (lost_r != 8'hFF) lost_s = lost_r + 8'd1;
                        else                 lost_s = lost_r;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAULT: state_s = ST_FAULT;
                default:  state_s = ST_PWD;
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        pwd_s   = 1'b0;
        prst_s  = 1'b0;
        ready_s = 1'b0;
        fault_s = 1'b0;
        case (state_s)
            ST_PWD:       begin pwd_s = 1'b1; prst_s = 1'b1; end
            ST_RST:       prst_s  = 1'b1;
            ST_WAIT_LOCK: prst_s  = 1'b0;
            ST_STABLE:    prst_s  = 1'b0;
            ST_RUN:       ready_s = 1'b1;
            ST_FAULT:     begin pwd_s = 1'b1; prst_s = 1'b1; fault_s = 1'b1; end
            default:      begin pwd_s = 1'b1; prst_s = 1'b1; end
        endcase
    end

    // State, phase counter, bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_PWD;
            cnt_r     <= 16'd0;
            retry_r   <= 4'd0;
            lost_r    <= 8'd0;
            pll_pwd   <= 1'b1;
            pll_rst   <= 1'b1;
            clk_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_r <= state_s;
            if (soft_restart || (state_s != state_r)) cnt_r <= 16'd0;
            else                                      cnt_r <= cnt_r + 16'd1;
            retry_r   <= retry_s;
            lost_r    <= lost_s;
            pll_pwd   <= pwd_s;
            pll_rst   <= prst_s;
            clk_ready <= ready_s;
            fault     <= fault_s;
        end
    end

endmodule
